// File: rtl/sync_memory_pkg.sv
// Shared types for sync_memory: FSM state, response record and byte-enable merge.
// Widths are fixed at the largest supported word (64 bits); users slice down.
package sync_memory_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } rsp_t;

  // Replace the bytes of old_word selected by be with the matching bytes of wdata.
  function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] wdata,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sync_memory.sv
// sync_memory: single-port word memory with valid/ready request and response
// channels, 1-cycle registered read, one-entry response register, error
// responses and a post-reset clear walker.
// Optional build macro SYNC_MEMORY_MISALIGN_EN: flag accesses whose low
// byte-offset bits are nonzero as errors instead of ignoring those bits.
//
// state | meaning
// CLEAR | walking the array writing zero, one word per cycle; requests blocked
// RUN   | serving requests
module sync_memory
  import sync_memory_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    WORDS          = 128,
  parameter int    ADDR_WIDTH     = 32,
  parameter string MEM_INIT       = "",
  parameter int    CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(BE_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF;
  localparam int MEM_AW = $clog2(WORDS);
  // A preloaded image must survive reset, so the walker is skipped when one is given.
  localparam bit     DO_CLEAR    = (CLEAR_ON_RESET != 0) && (MEM_INIT == "");
  localparam state_t RESET_STATE = DO_CLEAR ? CLEAR : RUN;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  state_t                    state_q, state_d;
  logic [MEM_AW-1:0]         cnt_q, cnt_d;
  logic                      live_q;
  logic                      rsp_valid_q;
  rsp_t                      rsp_q, rsp_d;
  logic                      accept;
  logic [IDX_W-1:0]          idx;
  logic [MEM_AW-1:0]         mem_idx;
  logic                      in_range;
  logic                      bad_align;
  logic                      req_err;
  logic [MAX_DATA_WIDTH-1:0] old_wide, merged;
  logic                      mem_we;
  logic [MEM_AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;

  // State, clear counter and a one-shot flag that keeps req_ready low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  // Next state, clear progress, busy and request backpressure.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (cnt_q == MEM_AW'(WORDS - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: req_ready = live_q && (!rsp_valid_q || rsp_ready);
    endcase
  end

  // Request decode, error classification and the single RAM write port mux.
  always_comb begin
    accept   = req_valid && req_ready;
    idx      = req_addr[ADDR_WIDTH-1:OFF];
    mem_idx  = idx[MEM_AW-1:0];
    in_range = idx < IDX_W'(WORDS);
`ifdef SYNC_MEMORY_MISALIGN_EN
    bad_align = |req_addr[OFF-1:0];
`else
    bad_align = 1'b0;
`endif
    req_err  = !in_range || bad_align;
    old_wide = MAX_DATA_WIDTH'(mem[mem_idx]);
    merged   = be_merge(old_wide, MAX_DATA_WIDTH'(req_wdata), MAX_BE_WIDTH'(req_be));

    rsp_d.err   = req_err;
    rsp_d.rdata = (!req_write && !req_err) ? old_wide : '0;

    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we    = accept && req_write && !req_err;
      mem_addr  = mem_idx;
      mem_wdata = merged[DATA_WIDTH-1:0];
    end
  end

  // Array write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // One-entry response register: loads on accept, empties when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef SYNC_MEMORY_MISALIGN_EN
`ifndef SYNTHESIS
  // Report misaligned accesses in simulation.
  always_ff @(posedge clk) begin
    if (accept && bad_align) $display("sync_memory: misaligned access at 0x%0h", req_addr);
  end
`endif
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_sync_memory.sv
// Directed + random bench for sync_memory (default build, 32-bit x 128 words).
module tb_sync_memory;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [128];

  sync_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: word index is the byte address divided by 4; beyond 128 words is an error.
  task automatic model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output logic err);
    int unsigned i;
    i = a / 4;
    rd = 32'h0;
    err = 1'b0;
    if (i >= 128) begin
      err = 1'b1;
    end else if (w) begin
      for (int b = 0; b < 4; b++) if (be[b]) model[i][8*b +: 8] = d[8*b +: 8];
    end else begin
      rd = model[i];
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    logic [31:0] exp_rd;
    logic exp_err;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("req_accept_timeout", req_ready, 1);
    model_op(w, a, d, be, exp_rd, exp_err);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
  endtask

  // Called at a negedge with rst_n low; releases reset and measures the clear walk.
  task automatic release_and_count();
    int n;
    int bad;
    for (int i = 0; i < 128; i++) model[i] = 32'h0;
    rst_n = 1'b1;
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (req_ready !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    check("clear_cycles", n, 128);
    check("ready_low_during_clear", bad, 0);
    check("ready_after_clear", req_ready, 1);
  endtask

  initial begin
    logic [31:0] a_data, b_data, c_data;
    logic        w;
    logic [31:0] a;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    // Reset values and full clear walk.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 1);
    release_and_count();
    for (int i = 0; i < 128; i++) do_req(1'b0, 32'(i * 4), 32'h0, 4'h0);

    // Write then read back-to-back, then partial byte write.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'h0);
    check("read_after_write_const", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    do_req(1'b0, 32'h10, 32'h0, 4'h0);
    check("byte_merge_const", rsp_rdata, 32'hDEADBEAA);

    // Range errors, ignored low bits, empty byte-enable write.
    do_req(1'b0, 32'h200, 32'h0, 4'h0);
    do_req(1'b1, 32'h204, 32'h55555555, 4'hF);
    do_req(1'b0, 32'h11, 32'h0, 4'h0);
    do_req(1'b1, 32'h20, 32'h12345678, 4'h0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0);
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);

    // Random traffic against the model.
    repeat (300) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 32'h23F));
      do_req(w, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Backpressure with three queued reads.
    a_data = $urandom;
    b_data = $urandom;
    c_data = $urandom;
    do_req(1'b1, 32'h40, a_data, 4'hF);
    do_req(1'b1, 32'h44, b_data, 4'hF);
    do_req(1'b1, 32'h48, c_data, 4'hF);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_be    = 4'h0;
    req_addr  = 32'h40;
    check("bp_first_ready", req_ready, 1);
    @(negedge clk);
    req_addr = 32'h44;
    repeat (3) begin
      check("bp_ready_low", req_ready, 0);
      check("bp_valid_held", rsp_valid, 1);
      check("bp_data_stable", rsp_rdata, model[16]);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_release", req_ready, 1);
    @(negedge clk);
    req_addr = 32'h48;
    check("bp_second_valid", rsp_valid, 1);
    check("bp_second_data", rsp_rdata, model[17]);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_third_valid", rsp_valid, 1);
    check("bp_third_data", rsp_rdata, model[18]);
    @(negedge clk);
    check("bp_drained", rsp_valid, 0);

    // Reset drops a pending response; reset mid-clear restarts the walk.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    check("pending_before_reset", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_rsp", rsp_valid, 0);
    check("reset_busy", busy, 1);
    check("reset_ready", req_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_clear_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_clear_rsp_valid", rsp_valid, 0);
    check("mid_clear_reset_busy", busy, 1);
    @(negedge clk);
    release_and_count();
    do_req(1'b0, 32'h10, 32'h0, 4'h0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0);
    do_req(1'b0, 32'h44, 32'h0, 4'h0);
    do_req(1'b0, 32'h1FC, 32'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
